// File: rtl/uart_mmio_ctrl.sv
// UART memory-mapped register front end: CONFIG/STATUS/DATA/COMMAND decode, TX holding-register
// sequencer and RX buffer with sticky error flags. Define UART_RX_FIFO_EN for a multi-entry RX FIFO.
module uart_mmio_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [1:0]            cpu_addr_i,
  input  logic                  cpu_wr_en_i,
  input  logic                  cpu_rd_en_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_start_o,
  input  logic                  tx_busy_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_valid_i,
  input  logic                  rx_frame_err_i,
  output logic [1:0]            cfg_baud_sel_o,
  output logic                  irq_o
);

  typedef enum logic [1:0] {
    REG_CONFIG  = 2'b00,
    REG_STATUS  = 2'b01,
    REG_DATA    = 2'b10,
    REG_COMMAND = 2'b11
  } uart_reg_offset_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_ISSUE,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_e;

  if (DATA_WIDTH < 8 || RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_param_chk
    $error("uart_mmio_ctrl: DATA_WIDTH must be >= 8 and RX_FIFO_DEPTH a power of 2 >= 2");
  end

  // ---------------- access decode (write wins over a same-cycle read)
  logic rd_acc, cfg_wr, data_wr, cmd_wr, data_rd;
  logic cmd_clr, cmd_rx_flush, cmd_tx_flush;
  tx_state_e state_q, state_d;

  assign rd_acc       = cpu_rd_en_i & ~cpu_wr_en_i;
  assign cfg_wr       = cpu_wr_en_i & (cpu_addr_i == REG_CONFIG);
  assign data_wr      = cpu_wr_en_i & (cpu_addr_i == REG_DATA);
  assign cmd_wr       = cpu_wr_en_i & (cpu_addr_i == REG_COMMAND);
  assign data_rd      = rd_acc & (cpu_addr_i == REG_DATA);
  assign cmd_clr      = cmd_wr & cpu_wdata_i[0];
  assign cmd_rx_flush = cmd_wr & cpu_wdata_i[1];
  assign cmd_tx_flush = cmd_wr & cpu_wdata_i[2] & (state_q == TX_IDLE);

  // ---------------- CONFIG
  logic [4:0] cfg_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i)  cfg_q <= '0;
    else if (cfg_wr) cfg_q <= cpu_wdata_i[4:0];
  end

  assign cfg_baud_sel_o = cfg_q[3:2];

  // ---------------- TX holding register and sequencer
  logic [DATA_WIDTH-1:0] hold_q, hold_d, tx_data_q, tx_data_d;
  logic                  hold_full_q, hold_full_d, tx_ready, tx_ovf_set;

  // The holding register counts as empty during ISSUE since it is being handed off that cycle.
  assign tx_ready = ~hold_full_q | (state_q == TX_ISSUE);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_data_d   = tx_data_q;
    tx_ovf_set  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (hold_full_q && cfg_q[0] && !cmd_tx_flush) begin
          state_d   = TX_ISSUE;
          tx_data_d = hold_q;
        end
      end
      TX_ISSUE: begin
        hold_full_d = 1'b0;
        state_d     = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: if (tx_busy_i)  state_d = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!tx_busy_i) state_d = TX_IDLE;
      default:      state_d = TX_IDLE;
    endcase
    if (cmd_tx_flush) hold_full_d = 1'b0;
    if (data_wr) begin
      if (tx_ready) begin
        hold_d      = cpu_wdata_i;
        hold_full_d = 1'b1;
      end else begin
        tx_ovf_set  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= TX_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign tx_start_o = (state_q == TX_ISSUE);
  assign tx_data_o  = tx_data_q;

  // ---------------- RX buffer
  logic                  rx_push_req, rx_frame_set, rx_pop, rx_push, rx_ovr_set;
  logic                  rx_nonempty, rx_full;
  logic [DATA_WIDTH-1:0] rx_head;

  assign rx_push_req  = rx_valid_i & cfg_q[1] & ~rx_frame_err_i;
  assign rx_frame_set = rx_valid_i & cfg_q[1] & rx_frame_err_i;
  assign rx_pop       = data_rd & rx_nonempty;
  // A same-cycle pop frees the slot before the push lands.
  assign rx_ovr_set   = rx_push_req & rx_full & ~rx_pop;
  assign rx_push      = rx_push_req & ~rx_ovr_set & ~cmd_rx_flush;

`ifdef UART_RX_FIFO_EN
  localparam int PW = $clog2(RX_FIFO_DEPTH);
  logic [DATA_WIDTH-1:0] rx_mem [RX_FIFO_DEPTH];
  logic [PW-1:0]         rx_wptr_q, rx_rptr_q;
  logic [PW:0]           rx_cnt_q;

  assign rx_nonempty = (rx_cnt_q != '0);
  assign rx_full     = (rx_cnt_q == (PW+1)'(RX_FIFO_DEPTH));
  assign rx_head     = rx_mem[rx_rptr_q];

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wptr_q] <= rx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || cmd_rx_flush) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
        2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
        default: rx_cnt_q <= rx_cnt_q;
      endcase
    end
  end
`else
  logic [DATA_WIDTH-1:0] rx_byte_q;
  logic                  rx_full_q;

  assign rx_nonempty = rx_full_q;
  assign rx_full     = rx_full_q;
  assign rx_head     = rx_byte_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rx_byte_q <= '0;
      rx_full_q <= 1'b0;
    end else if (cmd_rx_flush) begin
      rx_full_q <= 1'b0;
    end else if (rx_push) begin
      rx_byte_q <= rx_data_i;
      rx_full_q <= 1'b1;
    end else if (rx_pop) begin
      rx_full_q <= 1'b0;
    end
  end
`endif

  // ---------------- sticky flags: a new error beats a same-cycle clear
  logic overrun_q, frame_err_q, tx_ovf_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_ovf_q    <= 1'b0;
    end else begin
      overrun_q   <= rx_ovr_set   | (overrun_q   & ~cmd_clr);
      frame_err_q <= rx_frame_set | (frame_err_q & ~cmd_clr);
      tx_ovf_q    <= tx_ovf_set   | (tx_ovf_q    & ~cmd_clr);
    end
  end

  // ---------------- read data
  logic [5:0]            status;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign status = {tx_ovf_q, tx_busy_i, frame_err_q, overrun_q, rx_nonempty, tx_ready};

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rdata_q <= '0;
    end else if (rd_acc) begin
      case (cpu_addr_i)
        REG_CONFIG: rdata_q <= {{(DATA_WIDTH-5){1'b0}}, cfg_q};
        REG_STATUS: rdata_q <= {{(DATA_WIDTH-6){1'b0}}, status};
        REG_DATA:   rdata_q <= rx_nonempty ? rx_head : '0;
        default:    rdata_q <= '0;
      endcase
    end
  end

  assign cpu_rdata_o = rdata_q;
  assign irq_o       = cfg_q[4] & rx_nonempty;

endmodule
